// File: rtl/camera_control_defs.sv
// Shared camera-path definitions: FIFO word layout, frame-start marker and DVP timing states.
package camera_control_defs;

  localparam int unsigned QueueWidth = 17;
  localparam int unsigned MarkerBit  = 16;
  localparam logic [QueueWidth-1:0] FrameMarker = 17'h10000;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StActive,
    StVfp
  } dvp_state_e;

  function automatic logic is_marker(logic [QueueWidth-1:0] word);
    return word[MarkerBit] && (word[MarkerBit-1:0] == FrameMarker[MarkerBit-1:0]);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_dvp_emulator_if.sv
// Pixel FIFO read port plus DVP camera outputs and status flags of the emulator.
interface cam_dvp_emulator_if;
  import camera_control_defs::*;

  logic [QueueWidth-1:0] queue_data;
  logic                  queue_empty;
  logic                  queue_rd_en;
  logic                  cam_vsync;
  logic                  href;
  logic [7:0]            p_data;
  logic                  frame_done;
  logic                  underrun;
  logic                  marker_error;

  modport master (
    input  queue_data, queue_empty,
    output queue_rd_en, cam_vsync, href, p_data, frame_done, underrun, marker_error
  );

  modport slave (
    output queue_data, queue_empty,
    input  queue_rd_en, cam_vsync, href, p_data, frame_done, underrun, marker_error
  );

endinterface

// File: rtl/cam_dvp_prefetch.sv
// One-word prefetch buffer in front of the pixel FIFO; flags frame-start markers as they land.
module cam_dvp_prefetch
  import camera_control_defs::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [QueueWidth-1:0] queue_data_i,
  input  logic                  queue_empty_i,
  input  logic                  fetch_en_i,
  input  logic                  keep_i,
  input  logic                  consume_i,
  output logic                  queue_rd_en_o,
  output logic [15:0]           buf_o,
  output logic                  buf_valid_o,
  output logic                  marker_o
);

  logic        pending_q, pending_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_q, buf_d;

  always_comb begin
    queue_rd_en_o = reset_n & fetch_en_i & ~queue_empty_i & ~pending_q &
                    (~buf_valid_q | consume_i);
    marker_o      = pending_q & is_marker(queue_data_i);
    pending_d     = queue_rd_en_o;
    buf_d         = buf_q;
    buf_valid_d   = buf_valid_q;
    if (consume_i) buf_valid_d = 1'b0;
    // Words landing while not keeping (hunting for a marker) are dropped.
    if (pending_q && !marker_o && keep_i) begin
      buf_d       = queue_data_i[15:0];
      buf_valid_d = 1'b1;
    end
    if (marker_o) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end

  assign buf_o       = buf_q;
  assign buf_valid_o = buf_valid_q;

endmodule

// File: rtl/cam_dvp_emulator.sv
// DVP camera emulator: replays FIFO frames as registered vsync/href/byte timing.
module cam_dvp_emulator
  import camera_control_defs::*;
#(
  parameter int unsigned FRAME_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT  = 480,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_PORCH  = 17,
  parameter int unsigned V_FRONT_PORCH = 10
) (
  input logic                clk,
  input logic                reset_n,
  cam_dvp_emulator_if.master bus
);

  localparam int unsigned LINE_PERIOD = 2 * FRAME_WIDTH + H_BLANK;
  localparam int unsigned ActiveBytes = 2 * FRAME_WIDTH;
  localparam int unsigned VMax = max_u(max_u(VSYNC_LINES, V_BACK_PORCH),
                                       max_u(FRAME_HEIGHT, V_FRONT_PORCH));
  localparam int unsigned HcntW = (LINE_PERIOD > 1) ? $clog2(LINE_PERIOD) : 1;
  localparam int unsigned VcntW = (VMax > 1) ? $clog2(VMax) : 1;

  dvp_state_e       state_q, state_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic [VcntW-1:0] vcnt_q, vcnt_d;
  logic             cam_vsync_q, cam_vsync_d;
  logic             href_q, href_d;
  logic [7:0]       p_data_q, p_data_d;
  logic [7:0]       pix_lo_q, pix_lo_d;
  logic             frame_done_q, frame_done_d;
  logic             underrun_q, underrun_d;
  logic             marker_error_q, marker_error_d;

  logic        line_end, in_href, consume, last_pix, fetch_en, keep;
  logic        rd_en, buf_valid, marker;
  logic [15:0] buf_word;

  cam_dvp_prefetch u_prefetch (
    .clk           (clk),
    .reset_n       (reset_n),
    .queue_data_i  (bus.queue_data),
    .queue_empty_i (bus.queue_empty),
    .fetch_en_i    (fetch_en),
    .keep_i        (keep),
    .consume_i     (consume),
    .queue_rd_en_o (rd_en),
    .buf_o         (buf_word),
    .buf_valid_o   (buf_valid),
    .marker_o      (marker)
  );

  always_comb begin
    line_end = (32'(hcnt_q) == LINE_PERIOD - 1);
    in_href  = (state_q == StActive) && (32'(hcnt_q) < ActiveBytes);
    consume  = in_href && !hcnt_q[0];
    // Stop fetching once the frame's last pixel is consumed so the next marker waits in the FIFO.
    last_pix = (state_q == StActive) && (32'(vcnt_q) == FRAME_HEIGHT - 1) &&
               (32'(hcnt_q) >= ActiveBytes - 2);
    fetch_en = ((state_q == StIdle) || (state_q == StVbp) || (state_q == StActive)) && !last_pix;
    keep     = (state_q != StIdle);

    state_d      = state_q;
    hcnt_d       = hcnt_q + 1'b1;
    vcnt_d       = vcnt_q;
    frame_done_d = 1'b0;
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = vcnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle:   if (marker) state_d = StVsync;
      StVsync:  if (line_end && 32'(vcnt_q) == VSYNC_LINES - 1) state_d = StVbp;
      StVbp: begin
        if (marker) state_d = StVsync;
        else if (line_end && 32'(vcnt_q) == V_BACK_PORCH - 1) state_d = StActive;
      end
      StActive: begin
        if (marker) state_d = StVsync;
        else if (line_end && 32'(vcnt_q) == FRAME_HEIGHT - 1) state_d = StVfp;
      end
      StVfp: begin
        if (line_end && 32'(vcnt_q) == V_FRONT_PORCH - 1) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default:  state_d = StIdle;
    endcase

    if (state_q == StIdle || state_d != state_q) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end

    cam_vsync_d    = (state_q == StIdle) || (state_q == StVsync);
    href_d         = in_href;
    p_data_d       = '0;
    pix_lo_d       = pix_lo_q;
    if (consume) begin
      p_data_d = buf_valid ? buf_word[15:8] : 8'h00;
      pix_lo_d = buf_valid ? buf_word[7:0] : 8'h00;
    end else if (in_href) begin
      p_data_d = pix_lo_q;
    end
    underrun_d     = underrun_q | (consume & ~buf_valid);
    marker_error_d = marker_error_q | (marker & ((state_q == StVbp) | (state_q == StActive)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      cam_vsync_q    <= 1'b1;
      href_q         <= 1'b0;
      p_data_q       <= '0;
      pix_lo_q       <= '0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
      marker_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      cam_vsync_q    <= cam_vsync_d;
      href_q         <= href_d;
      p_data_q       <= p_data_d;
      pix_lo_q       <= pix_lo_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
      marker_error_q <= marker_error_d;
    end
  end

  assign bus.queue_rd_en  = rd_en;
  assign bus.cam_vsync    = cam_vsync_q;
  assign bus.href         = href_q;
  assign bus.p_data       = p_data_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.underrun     = underrun_q;
  assign bus.marker_error = marker_error_q;

endmodule

// File: tb/tb_cam_dvp_emulator.sv
// Bench for cam_dvp_emulator: FIFO model, frame-level reference model and DVP receiver.
module tb_cam_dvp_emulator;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int HB   = 4;
  localparam int LP   = 2 * W + HB;
  localparam int NPIX = W * H;
  localparam int FL   = LP + H * LP + LP;  // back porch + active + front porch
  localparam logic [16:0] MARK = 17'h10000;

  typedef struct packed {
    logic [NPIX-1:0][15:0] px;
    logic                  aborted;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cam_dvp_emulator_if bus ();

  cam_dvp_emulator #(
    .FRAME_WIDTH   (W),
    .FRAME_HEIGHT  (H),
    .H_BLANK       (HB),
    .VSYNC_LINES   (1),
    .V_BACK_PORCH  (1),
    .V_FRONT_PORCH (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] fifo[$];
  logic [16:0] stim[$];
  frame_t      exp_q[$];
  logic        exp_ur, exp_me;
  logic        tv[$], th[$], tf[$];
  logic [7:0]  tp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    if (r[16:0] == MARK) return 17'h00001;
    return r[16:0];
  endfunction

  task automatic push_word(input logic [16:0] w);
    fifo.push_back(w);
    stim.push_back(w);
    bus.queue_empty = 1'b0;
  endtask

  task automatic clear_trace();
    tv.delete(); th.delete(); tf.delete(); tp.delete();
  endtask

  // One clock: FIFO pops on a sampled read strobe, data valid after the edge.
  task automatic step();
    logic rd;
    #1 rd = bus.queue_rd_en;
    @(posedge clk);
    #1;
    if (rd && fifo.size() > 0) bus.queue_data = fifo.pop_front();
    bus.queue_empty = (fifo.size() == 0);
    tv.push_back(bus.cam_vsync);
    th.push_back(bus.href);
    tp.push_back(bus.p_data);
    tf.push_back(bus.frame_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fifo.delete(); stim.delete(); exp_q.delete();
    exp_ur = 1'b0;
    exp_me = 1'b0;
    bus.queue_data  = '0;
    bus.queue_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vsync", 32'(bus.cam_vsync), 32'(1));
    check("rst_href", 32'(bus.href), 32'(0));
    check("rst_pdata", 32'(bus.p_data), 32'(0));
    check("rst_rd_en", 32'(bus.queue_rd_en), 32'(0));
    check("rst_flags", 32'({bus.frame_done, bus.underrun, bus.marker_error}), 32'(0));
    bus.queue_empty = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b1;
    clear_trace();
  endtask

  // Frame-level model: hunt for a marker, collect NPIX words; a marker mid-frame aborts
  // and restarts; a short tail is padded with zero pixels and flags underrun.
  task automatic predict();
    frame_t cur;
    int     n;
    logic   in_frame;
    cur = '0;
    n = 0;
    in_frame = 1'b0;
    foreach (stim[i]) begin
      if (stim[i] == MARK) begin
        if (in_frame) begin
          cur.aborted = 1'b1;
          exp_q.push_back(cur);
          exp_me = 1'b1;
        end
        in_frame = 1'b1;
        n = 0;
        cur = '0;
      end else if (in_frame) begin
        cur.px[n] = stim[i][15:0];
        n++;
        if (n == NPIX) begin
          exp_q.push_back(cur);
          in_frame = 1'b0;
        end
      end
    end
    if (in_frame) begin
      exp_q.push_back(cur);
      exp_ur = 1'b1;
    end
    stim.delete();
  endtask

  task automatic analyze();
    int         n_done, fd_total, stray, hi, lo, fdw, prev, a, ln, j, nb;
    frame_t     f;
    logic       eh;
    logic [7:0] ep, hb;
    logic [15:0] px;
    logic [15:0] rx[$];
    n_done = 0; fd_total = 0; stray = 0; prev = -1;
    for (int i = 0; i < tf.size(); i++) begin
      fd_total += int'(tf[i]);
      if (!th[i] && tp[i] != 8'h00) stray++;
    end
    for (int i = 1; i < tv.size(); i++) begin
      if (tv[i-1] && !tv[i]) begin
        hi = 0;
        for (int k = i - 1; k >= 0 && tv[k]; k--) hi++;
        check("vsync_hi_min", 32'(hi >= LP), 32'(1));
        if (prev >= 0) check("vsync_hi_b2b", 32'(hi <= LP + 4), 32'(1));
        prev = i;
        if (exp_q.size() == 0) begin
          check("extra_frame", 32'(1), 32'(0));
        end else begin
          f = exp_q.pop_front();
          if (f.aborted) begin
            lo = 0; fdw = 0;
            for (int k = i; k < tv.size() && !tv[k]; k++) begin
              lo++;
              fdw += int'(tf[k]);
            end
            check("abort_low_len", 32'(lo < FL), 32'(1));
            check("abort_fd", 32'(fdw), 32'(0));
          end else if (i + FL >= tv.size()) begin
            check("frame_trunc", 32'(1), 32'(0));
          end else begin
            rx.delete();
            nb = 0;
            hb = 8'h00;
            for (int k = 0; k < FL; k++) begin
              eh = 1'b0;
              ep = 8'h00;
              if (k >= LP && k < LP + H * LP) begin
                a  = k - LP;
                ln = a / LP;
                j  = a % LP;
                if (j < 2 * W) begin
                  eh = 1'b1;
                  px = f.px[ln * W + j / 2];
                  ep = (j % 2 == 1) ? px[7:0] : px[15:8];
                end
              end
              check("dvp_cycle", 32'({tv[i+k], th[i+k], tp[i+k], tf[i+k]}),
                    32'({1'b0, eh, ep, k == FL - 1}));
              if (th[i+k]) begin
                if (nb % 2 == 0) hb = tp[i+k];
                else rx.push_back({hb, tp[i+k]});
                nb++;
              end
            end
            check("vsync_after", 32'(tv[i+FL]), 32'(1));
            check("rx_count", 32'(rx.size()), 32'(NPIX));
            for (int p = 0; p < rx.size() && p < NPIX; p++)
              check("rx_pixel", 32'(rx[p]), 32'(f.px[p]));
            n_done++;
          end
        end
      end
    end
    check("fd_count", 32'(fd_total), 32'(n_done));
    check("pdata_idle", 32'(stray), 32'(0));
    check("frames_left", 32'(exp_q.size()), 32'(0));
    check("underrun", 32'(bus.underrun), 32'(exp_ur));
    check("marker_error", 32'(bus.marker_error), 32'(exp_me));
  endtask

  logic [15:0] ref_px[NPIX] = '{16'h1234, 16'h1345, 16'h1456, 16'h1567,
                                16'h1678, 16'h1789, 16'h1ABC, 16'h1BCD};

  initial begin
    int guard;

    // Basic frame from a fixed pixel table.
    do_reset();
    push_word(MARK);
    for (int i = 0; i < NPIX; i++) push_word({1'b0, ref_px[i]});
    predict();
    run(100);
    analyze();

    // Garbage ahead of the marker is discarded.
    do_reset();
    push_word(17'h0AAAA);
    push_word(17'h05555);
    push_word(rand_word());
    push_word(MARK);
    for (int i = 0; i < NPIX; i++) push_word({1'b0, ref_px[i]});
    predict();
    run(100);
    analyze();

    // Short frame: trailing pixels become zero and underrun sticks.
    do_reset();
    push_word(MARK);
    for (int i = 0; i < 5; i++) push_word(rand_word());
    predict();
    run(130);
    analyze();

    // Marker as the third pixel word aborts, then the next frame plays.
    do_reset();
    push_word(MARK);
    push_word(rand_word());
    push_word(rand_word());
    push_word(MARK);
    for (int i = 0; i < NPIX; i++) push_word(rand_word());
    predict();
    run(160);
    analyze();

    // Reset mid active line 1, then hunt for a fresh marker.
    do_reset();
    push_word(MARK);
    for (int i = 0; i < NPIX; i++) push_word(rand_word());
    stim.delete();
    guard = 0;
    step();
    while (tv[tv.size()-1] && guard < 100) begin
      step();
      guard++;
    end
    check("wait_vsync_fall", 32'(guard < 100), 32'(1));
    run(LP + LP + 4);
    #2 reset_n = 1'b0;
    #1;
    check("async_vsync", 32'(bus.cam_vsync), 32'(1));
    check("async_href", 32'(bus.href), 32'(0));
    check("async_pdata", 32'(bus.p_data), 32'(0));
    check("async_rd_en", 32'(bus.queue_rd_en), 32'(0));
    check("async_fd", 32'(bus.frame_done), 32'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    clear_trace();
    exp_q.delete();
    foreach (fifo[i]) stim.push_back(fifo[i]);
    run(40);
    push_word(MARK);
    for (int i = 0; i < NPIX; i++) push_word(rand_word());
    predict();
    run(100);
    analyze();

    // Three back-to-back frames.
    do_reset();
    for (int fr = 0; fr < 3; fr++) begin
      push_word(MARK);
      for (int i = 0; i < NPIX; i++) push_word(rand_word());
    end
    predict();
    run(3 * (FL + 2 * LP) + 40);
    analyze();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cam_dvp_emulator.md
CAM_DVP_EMULATOR -- requirements
Module: cam_dvp_emulator

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144, meaning href-low cycles per line; LINE_PERIOD = 2*FRAME_WIDTH + H_BLANK.
REQ-004 SHALL have parameters VSYNC_LINES, V_BACK_PORCH and V_FRONT_PORCH, defaults 3, 17 and 10, all in line periods.
REQ-005 SHALL have the following ports, one per line:
- clk  input  1  pixel clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- queue_data  input  17  FIFO Q; bit16=1 with bits[15:0]=0 is the frame-start marker, otherwise bits[15:0] are an RGB565 pixel.
- queue_empty  input  1  FIFO empty.
- queue_rd_en  output  1  FIFO read strobe; Q is valid one cycle after it.
- cam_vsync  output  1  high = vertical blanking/idle.
- href  output  1  high during active line bytes.
- p_data  output  8  DVP byte; high byte [15:8] first, then low byte [7:0].
- frame_done  output  1  one-cycle pulse at the end of each frame.
- underrun  output  1  sticky; set when a pixel is needed and the buffer is empty.
- marker_error  output  1  sticky; set when a marker arrives mid-frame.

Function
REQ-006 SHALL register all DVP outputs (cam_vsync, href, p_data) on posedge clk.
REQ-007 SHALL implement states IDLE, VSYNC, VBP, ACTIVE, VFP.
REQ-008 IDLE: cam_vsync=1, href=0; pop words while !queue_empty; discard non-marker words; on a marker go to VSYNC with hcnt=0, vcnt=0.
REQ-009 VSYNC: cam_vsync=1 for VSYNC_LINES*LINE_PERIOD cycles, then go to VBP.
REQ-010 VBP: cam_vsync=0, href=0 for V_BACK_PORCH*LINE_PERIOD cycles, then go to ACTIVE.
REQ-011 ACTIVE: per line, href=1 for hcnt 0..2*FRAME_WIDTH-1 and href=0 for the remaining H_BLANK cycles; even hcnt outputs the high byte and odd hcnt outputs the low byte of the same pixel word.
REQ-012 ACTIVE SHALL run FRAME_HEIGHT lines, then go to VFP.
REQ-013 VFP: cam_vsync=0, href=0 for V_FRONT_PORCH*LINE_PERIOD cycles; on the last cycle pulse frame_done and go to IDLE.
REQ-014 hcnt SHALL wrap at LINE_PERIOD-1 and increment vcnt; vcnt SHALL clear on each state change; counter widths SHALL be $clog2 of their maxima.
REQ-015 SHALL prefetch through a one-word buffer (buf, buf_valid) plus a pending flag.
REQ-016 queue_rd_en SHALL equal !queue_empty && !pending && (!buf_valid || consume), where consume is the even-hcnt href cycle in ACTIVE.
REQ-017 Prefetch SHALL be enabled in VBP, ACTIVE and IDLE; in VSYNC and VFP it SHALL be disabled.
REQ-018 A marker read in VBP or ACTIVE SHALL set marker_error, abort the frame (no frame_done) and go to VSYNC.
REQ-019 A consume with buf_valid=0 SHALL output 0x00 for both bytes of that pixel and set underrun; line and frame timing SHALL be unaffected.
REQ-020 The pixel value SHALL be held for its odd-hcnt byte even if the buffer refills in between.
REQ-021 p_data SHALL be 0 whenever href=0.

Reset
REQ-022 While reset_n=0: state=IDLE, cam_vsync=1, href=0, p_data=0, queue_rd_en=0, frame_done=0, underrun=0, marker_error=0, buf_valid=0, pending=0, counters=0.
REQ-023 Reset asserted mid-frame SHALL take effect immediately; after release, the block SHALL hunt for a new marker and SHALL NOT resume the old frame.

Structure
REQ-024 The marker value (17'h10000), the queue word width (17) and the marker bit index (16) SHALL live in the shared camera_control_defs header.
REQ-025 The prefetch buffer SHALL be one sub-module, cam_dvp_prefetch (rd_en, pending, buf, buf_valid, marker detect).
REQ-026 The timing FSM and counters SHALL live in cam_dvp_emulator.

Verification
Benches use FRAME_WIDTH=4, FRAME_HEIGHT=2, H_BLANK=4, VSYNC_LINES=1, V_BACK_PORCH=1, V_FRONT_PORCH=1, so LINE_PERIOD=12.
REQ-027 Reset, then a FIFO model holding marker + 8 pixels 0x1234..0x1BCD -> cam_vsync high 12 cycles, low 12; two lines each of 8 href cycles then 4 blank cycles, bytes 12 34 ...; frame_done one pulse after 12 VFP cycles; underrun=0.
REQ-028 Garbage words 0xAAAA, 0x5555 before the marker -> both discarded in IDLE, frame output identical to REQ-027.
REQ-029 Only 5 pixels after the marker -> pixels 6-8 output 00 00, underrun=1 and sticky, and the href pattern is unchanged.
REQ-030 A marker as the 3rd pixel word -> marker_error=1, cam_vsync returns high, no frame_done, and the following frame plays out correctly.
REQ-031 reset_n pulsed low during ACTIVE line 1 -> outputs reach reset values asynchronously, and the block waits for a new marker.
REQ-032 A receiver model (sample href and p_data on posedge, pair the bytes) SHALL reproduce the FIFO pixel sequence exactly across 3 back-to-back frames.
